// File: rtl/musa_fetch_unit.sv
// musa_fetch_unit: instruction fetch and next-PC unit for the MUSA core.
// The memory side is a req/ack handshake with variable latency. The decode
// side is a valid/ready handshake. A return-address stack is used by
// CALL/RET.
// Optional feature: define MUSA_FETCH_STACK_EN to build the return stack.
// Without it, CALL acts as JMP, RET acts as SEQ, and both stack flags read 0.
//
// Handshake semantics:
// - imem_req is high in every FETCH cycle, and imem_addr holds the PC.
// - A cycle with imem_ack high transfers imem_rdata, and the FSM leaves FETCH.
// - instr_valid is high in every VALID cycle, and instr is stable.
// - A cycle with instr_ready high consumes instr. br_* are sampled in that
//   same cycle.
// - Neither input reaches an output combinationally.
module musa_fetch_unit #(
  parameter int ADDR_W      = 18,
  parameter int INSTR_W     = 32,
  parameter int STACK_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic [2:0]         br_sel,
  input  logic               br_flag,
  input  logic [ADDR_W-1:0]  br_reg,
  input  logic [ADDR_W-1:0]  br_imm,
  output logic               halted,
  output logic               stack_overflow,
  output logic               stack_underflow
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_VALID = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  localparam logic [2:0] BR_SEQ  = 3'd0;
  localparam logic [2:0] BR_JR   = 3'd1;
  localparam logic [2:0] BR_JMP  = 3'd2;
  localparam logic [2:0] BR_HALT = 3'd3;
  localparam logic [2:0] BR_JPC  = 3'd4;
  localparam logic [2:0] BR_BRFL = 3'd5;
  localparam logic [2:0] BR_CALL = 3'd6;
  localparam logic [2:0] BR_RET  = 3'd7;

  // A zero-entry stack is meaningless, so reject it at elaboration.
  if (STACK_DEPTH < 1) begin : g_depth_check
    $error("musa_fetch_unit: STACK_DEPTH must be at least 1");
  end

  // state is kept as a named signal so checkers can probe the FSM directly.
  state_t               state;
  state_t               state_nxt;
  logic [ADDR_W-1:0]    pc;
  logic [ADDR_W-1:0]    pc_nxt;
  logic [ADDR_W-1:0]    pc_inc;
  logic [INSTR_W-1:0]   instr_q;
  logic                 accept;

  assign pc_inc = pc + 1'b1;
  assign accept = (state == S_VALID) && instr_ready;

`ifdef MUSA_FETCH_STACK_EN
  localparam int CNT_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
  logic [CNT_W-1:0]  count;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  pop_idx;
  logic              full;
  logic              empty;
  logic              do_push;
  logic              do_pop;
  logic              ovf_q;
  logic              unf_q;

  // The push slot is the count itself. The top entry sits one slot below it.
  // When a power-of-two stack is full, the truncated count wraps to 0, and
  // the minus-one wraps back to the top entry.
  assign push_idx = count[IDX_W-1:0];
  assign pop_idx  = push_idx - 1'b1;
  assign full     = (count == CNT_W'(STACK_DEPTH));
  assign empty    = (count == '0);
`endif

  // Next-PC selection, applied only when decode accepts the instruction.
  always_comb begin
    pc_nxt = pc_inc;
`ifdef MUSA_FETCH_STACK_EN
    do_push = 1'b0;
    do_pop  = 1'b0;
`endif
    case (br_sel)
      BR_SEQ:  pc_nxt = pc_inc;
      BR_JR:   pc_nxt = br_reg;
      BR_JMP:  pc_nxt = br_imm;
      BR_HALT: pc_nxt = pc;
      BR_JPC:  pc_nxt = pc + br_imm;
      BR_BRFL: pc_nxt = br_flag ? br_imm : pc_inc;
      BR_CALL: begin
        // A CALL on a full stack drops the push, but the jump is still taken.
        pc_nxt = br_imm;
`ifdef MUSA_FETCH_STACK_EN
        do_push = !full;
`endif
      end
      BR_RET: begin
        // A RET on an empty stack falls through to the next instruction.
        pc_nxt = pc_inc;
`ifdef MUSA_FETCH_STACK_EN
        if (!empty) begin
          pc_nxt = stack_mem[pop_idx];
          do_pop = 1'b1;
        end
`endif
      end
      default: pc_nxt = pc_inc;
    endcase
  end

  // FSM next state. HALT is left only through reset.
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: if (imem_ack) state_nxt = S_VALID;
      S_VALID: if (instr_ready) state_nxt = (br_sel == BR_HALT) ? S_HALT : S_FETCH;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_FETCH;
    endcase
  end

  // State, PC and the held instruction. All of them clear asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      pc      <= '0;
      instr_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH && imem_ack) instr_q <= imem_rdata;
      if (accept) pc <= pc_nxt;
    end
  end

`ifdef MUSA_FETCH_STACK_EN
  // Return-stack storage. It has no reset because the count qualifies every entry.
  always_ff @(posedge clk) begin
    if (accept && do_push) stack_mem[push_idx] <= pc_inc;
  end

  // Stack count and the sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (accept) begin
      if (do_push) count <= count + 1'b1;
      if (do_pop)  count <= count - 1'b1;
      if (br_sel == BR_CALL && full)  ovf_q <= 1'b1;
      if (br_sel == BR_RET  && empty) unf_q <= 1'b1;
    end
  end

  assign stack_overflow  = ovf_q;
  assign stack_underflow = unf_q;
`else
  assign stack_overflow  = 1'b0;
  assign stack_underflow = 1'b0;
`endif

  // The request is masked while reset is held, because the FSM already sits
  // in FETCH during reset. It therefore rises as soon as reset releases.
  assign imem_req    = (state == S_FETCH) & rst_n;
  assign imem_addr   = pc;
  assign instr       = instr_q;
  assign instr_valid = (state == S_VALID);
  assign halted      = (state == S_HALT);

endmodule

// File: tb/tb_musa_fetch_unit.sv
// tb_musa_fetch_unit: a directed bench for musa_fetch_unit (ADDR_W=18,
// STACK_DEPTH=2). Expected addresses are hand-computed for both builds, and
// MUSA_FETCH_STACK_EN selects which column applies.
module tb_musa_fetch_unit;

  localparam int AW = 18;
  localparam int IW = 32;
  localparam int SD = 2;

  localparam logic [2:0] SEQ  = 3'd0;
  localparam logic [2:0] JR   = 3'd1;
  localparam logic [2:0] JMP  = 3'd2;
  localparam logic [2:0] HLT  = 3'd3;
  localparam logic [2:0] JPC  = 3'd4;
  localparam logic [2:0] BRFL = 3'd5;
  localparam logic [2:0] CALL = 3'd6;
  localparam logic [2:0] RET  = 3'd7;

`ifdef MUSA_FETCH_STACK_EN
  localparam bit STACK_EN = 1'b1;
`else
  localparam bit STACK_EN = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [IW-1:0] imem_rdata;
  logic [IW-1:0] instr;
  logic          instr_valid;
  logic          instr_ready;
  logic [2:0]    br_sel;
  logic          br_flag;
  logic [AW-1:0] br_reg;
  logic [AW-1:0] br_imm;
  logic          halted;
  logic          stack_overflow;
  logic          stack_underflow;

  musa_fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .STACK_DEPTH(SD)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .instr           (instr),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .br_sel          (br_sel),
    .br_flag         (br_flag),
    .br_reg          (br_reg),
    .br_imm          (br_imm),
    .halted          (halted),
    .stack_overflow  (stack_overflow),
    .stack_underflow (stack_underflow)
  );

  // ---------------- clock / reset / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish within 200000 time units");
    $fatal(1, "watchdog");
  end

  // ---------------- vectors and scoreboard ----------------
  // Columns: addr_s is the expected fetch address with the stack built, and
  // addr_n is the expected address without it.
  typedef struct {
    logic [AW-1:0] addr_s;
    logic [AW-1:0] addr_n;
    int            waits;
    int            rwaits;
    logic [2:0]    sel;
    logic          flag;
    logic [AW-1:0] reg_v;
    logic [AW-1:0] imm;
    bit            ovf_s;
    bit            unf_s;
    int            gap;
  } vec_t;

  vec_t          vecs[$];
  logic [AW-1:0] exp_q[$];
  int            errors = 0;
  int            checks = 0;

  task automatic add_vec(input logic [AW-1:0] addr_s, input logic [AW-1:0] addr_n,
                         input int waits, input int rwaits, input logic [2:0] sel,
                         input logic flag, input logic [AW-1:0] reg_v,
                         input logic [AW-1:0] imm, input bit ovf_s, input bit unf_s,
                         input int gap);
    vec_t v;
    v.addr_s = addr_s; v.addr_n = addr_n; v.waits = waits; v.rwaits = rwaits;
    v.sel = sel; v.flag = flag; v.reg_v = reg_v; v.imm = imm;
    v.ovf_s = ovf_s; v.unf_s = unf_s; v.gap = gap;
    vecs.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Waits (bounded) for a request, checks the address, then acks after 'waits' cycles.
  task automatic fetch_one(input int waits, input logic [IW-1:0] data, output int t_ack);
    logic [AW-1:0] exp_addr;
    int k;
    k = 0;
    while (!imem_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("req_seen", 32'(imem_req), 32'd1);
    exp_addr = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    check("imem_addr", 32'(imem_addr), 32'(exp_addr));
    repeat (waits) @(negedge clk);
    check("req_held", 32'(imem_req), 32'd1);
    check("valid_low_in_fetch", 32'(instr_valid), 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = data;
    t_ack      = cyc;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    check("instr", instr, data);
    check("instr_valid", 32'(instr_valid), 32'd1);
  endtask

  // Stalls decode for rwaits cycles while pulsing a stray ack, then consumes.
  task automatic decode_one(input vec_t v, input logic [IW-1:0] data);
    repeat (v.rwaits) begin
      imem_ack   = 1'b1;
      imem_rdata = $urandom;
      @(negedge clk);
      imem_ack = 1'b0;
      check("instr_hold", instr, data);
      check("valid_hold", 32'(instr_valid), 32'd1);
    end
    instr_ready = 1'b1;
    br_sel      = v.sel;
    br_flag     = v.flag;
    br_reg      = v.reg_v;
    br_imm      = v.imm;
    @(negedge clk);
    instr_ready = 1'b0;
    br_sel      = SEQ;
    br_flag     = 1'b0;
    br_reg      = AW'($urandom);
    br_imm      = AW'($urandom);
    check("valid_drop", 32'(instr_valid), 32'd0);
    check("halted", 32'(halted), 32'(v.sel == HLT));
    check("stack_overflow", 32'(stack_overflow), 32'(STACK_EN & v.ovf_s));
    check("stack_underflow", 32'(stack_underflow), 32'(STACK_EN & v.unf_s));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t;
    int t_prev;
    logic [IW-1:0] data;
    vec_t v;

    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    br_sel = SEQ; br_flag = 1'b0; br_reg = '0; br_imm = '0;

    //      addr_s    addr_n    w  rw sel   f  reg       imm     ov un gap
    add_vec(18'h0,    18'h0,    0, 0, SEQ,  0, 18'h0,    18'h0,  0, 0, 0);
    add_vec(18'h1,    18'h1,    0, 0, SEQ,  0, 18'h0,    18'h0,  0, 0, 2);
    add_vec(18'h2,    18'h2,    3, 0, SEQ,  0, 18'h0,    18'h0,  0, 0, 5);
    add_vec(18'h3,    18'h3,    0, 2, SEQ,  0, 18'h0,    18'h0,  0, 0, 2);
    add_vec(18'h4,    18'h4,    1, 0, SEQ,  0, 18'h0,    18'h0,  0, 0, 5);
    add_vec(18'h5,    18'h5,    0, 0, JR,   0, 18'h100,  18'h7,  0, 0, 0);
    add_vec(18'h100,  18'h100,  2, 0, JMP,  0, 18'h9,    18'h20, 0, 0, 0);
    add_vec(18'h20,   18'h20,   0, 0, BRFL, 0, 18'h0,    18'h40, 0, 0, 0);
    add_vec(18'h21,   18'h21,   0, 0, BRFL, 1, 18'h0,    18'h40, 0, 0, 0);
    add_vec(18'h40,   18'h40,   0, 0, JR,   0, 18'h3FFFF,18'h0,  0, 0, 0);
    add_vec(18'h3FFFF,18'h3FFFF,0, 0, JPC,  0, 18'h0,    18'h2,  0, 0, 0);
    add_vec(18'h1,    18'h1,    0, 0, JMP,  0, 18'h0,    18'h3,  0, 0, 0);
    add_vec(18'h3,    18'h3,    0, 0, CALL, 0, 18'h0,    18'h10, 0, 0, 0);
    add_vec(18'h10,   18'h10,   0, 0, CALL, 0, 18'h0,    18'h20, 0, 0, 0);
    add_vec(18'h20,   18'h20,   1, 0, RET,  0, 18'h0,    18'h0,  0, 0, 0);
    add_vec(18'h11,   18'h21,   0, 0, RET,  0, 18'h0,    18'h0,  0, 0, 0);
    add_vec(18'h4,    18'h22,   0, 0, CALL, 0, 18'h0,    18'h50, 0, 0, 0);
    add_vec(18'h50,   18'h50,   0, 0, CALL, 0, 18'h0,    18'h60, 0, 0, 0);
    add_vec(18'h60,   18'h60,   0, 0, CALL, 0, 18'h0,    18'h70, 1, 0, 0);
    add_vec(18'h70,   18'h70,   0, 0, RET,  0, 18'h0,    18'h0,  1, 0, 0);
    add_vec(18'h51,   18'h71,   0, 0, RET,  0, 18'h0,    18'h0,  1, 0, 0);
    add_vec(18'h5,    18'h72,   0, 0, RET,  0, 18'h0,    18'h0,  1, 1, 0);
    add_vec(18'h6,    18'h73,   0, 0, RET,  0, 18'h0,    18'h0,  1, 1, 0);
    add_vec(18'h7,    18'h74,   0, 0, JMP,  0, 18'h0,    18'h7,  1, 1, 0);
    add_vec(18'h7,    18'h7,    0, 0, HLT,  0, 18'h0,    18'h0,  1, 1, 0);

    foreach (vecs[i]) exp_q.push_back(STACK_EN ? vecs[i].addr_s : vecs[i].addr_n);

    // Reset values while rst_n is held low.
    repeat (3) @(negedge clk);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_ovf", 32'(stack_overflow), 32'd0);
    check("rst_unf", 32'(stack_underflow), 32'd0);
    rst_n = 1'b1;
    #1;
    check("req_after_release", 32'(imem_req), 32'd1);

    t_prev = 0;
    foreach (vecs[i]) begin
      v    = vecs[i];
      data = {8'hA5, 6'(i), (STACK_EN ? v.addr_s : v.addr_n)};
      fetch_one(v.waits, data, t);
      if (v.gap != 0) check("instr_gap", 32'(t - t_prev), 32'(v.gap));
      t_prev = t;
      decode_one(v, data);
    end

    // Halted at pc=7. Stray ack/ready pulses must have no effect.
    for (int c = 0; c < 10; c++) begin
      imem_ack    = 1'($urandom_range(0, 1));
      instr_ready = 1'($urandom_range(0, 1));
      br_sel      = 3'($urandom_range(0, 7));
      @(negedge clk);
      check("halt_halted", 32'(halted), 32'd1);
      check("halt_req", 32'(imem_req), 32'd0);
      check("halt_valid", 32'(instr_valid), 32'd0);
      check("halt_pc", 32'(imem_addr), 32'h7);
    end
    imem_ack = 1'b0; instr_ready = 1'b0; br_sel = SEQ;

    // Asynchronous reset pulse in the middle of a cycle.
    #2;
    rst_n = 1'b0;
    #1;
    check("rst2_halted", 32'(halted), 32'd0);
    check("rst2_req", 32'(imem_req), 32'd0);
    check("rst2_addr", 32'(imem_addr), 32'd0);
    check("rst2_instr", instr, 32'd0);
    check("rst2_ovf", 32'(stack_overflow), 32'd0);
    check("rst2_unf", 32'(stack_underflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst2_req_release", 32'(imem_req), 32'd1);

    // One sequential instruction after reset.
    v.addr_s = '0; v.addr_n = '0; v.waits = 0; v.rwaits = 0; v.sel = SEQ;
    v.flag = 1'b0; v.reg_v = '0; v.imm = '0; v.ovf_s = 1'b0; v.unf_s = 1'b0; v.gap = 0;
    exp_q.push_back(18'h0);
    fetch_one(0, 32'h1234_5678, t);
    decode_one(v, 32'h1234_5678);
    check("post_reset_next_addr", 32'(imem_addr), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
